// File: rtl/counter_nbit_up_down_mod.sv
// ---------------------------------------------------------------------------
// counter_nbit_up_down_mod
//
// WIDTH-bit up/down counter with a programmable terminal value (MAX_VAL).
// When a limit is reached it either wraps or saturates. Also provides a
// parallel load, a terminal-count indication, a one-cycle wrap pulse and a
// sticky overflow flag.
//
// Parameters
//   WIDTH     counter width in bits
//   MAX_VAL   terminal value, legal range 1 .. 2**WIDTH-1
//   SATURATE  0 = wrap at the limits, 1 = hold at the limits
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   en         in   count enable
//   direction  in   0 = up, 1 = down
//   load       in   synchronous parallel load strobe (takes priority over en)
//   load_val   in   value to load, clamped to MAX_VAL
//   count_out  out  registered count
//   tc         out  terminal count for the current direction (combinational)
//   wrap       out  registered pulse, high the cycle after a limit crossing
//   ovf        out  sticky flag for any crossing or saturation attempt;
//                   cleared only by rst or load
// ---------------------------------------------------------------------------
module counter_nbit_up_down_mod #(
    parameter int WIDTH    = 3,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             direction,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count_out,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ZERO_C = '0;
    localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q,  wrap_d;
    logic             ovf_q,   ovf_d;

    // Limit detection for the direction sampled this cycle. The up limit
    // uses >= so the count can never climb above MAX_VAL.
    logic at_up_limit;
    logic at_down_limit;

    assign at_up_limit   = (count_q >= MAX_C);
    assign at_down_limit = (count_q == ZERO_C);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can
        // leave it unassigned and infer a latch.
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;

        if (load) begin
            count_d = (load_val > MAX_C) ? MAX_C : load_val;
            ovf_d   = 1'b0;
        end else if (en) begin
            if (!direction) begin
                if (at_up_limit) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) begin
                        count_d = ZERO_C;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + ONE_C;
                end
            end else begin
                if (at_down_limit) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) begin
                        count_d = MAX_C;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - ONE_C;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments for all state, so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            count_q <= ZERO_C;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_out = count_q;
    assign wrap      = wrap_q;
    assign ovf       = ovf_q;
    // Not gated by en: reflects where the counter sits for the chosen direction.
    assign tc        = direction ? (count_q == ZERO_C) : (count_q == MAX_C);

endmodule

// File: tb/tb_counter_nbit_up_down_mod.sv
// ---------------------------------------------------------------------------
// tb_counter_nbit_up_down_mod
//
// Three counter instances share one set of inputs:
//   u_wrap5  WIDTH=3, MAX_VAL=5, SATURATE=0
//   u_sat5   WIDTH=3, MAX_VAL=5, SATURATE=1
//   u_def    default parameters (WIDTH=3, MAX_VAL=7, SATURATE=0)
// Each scenario task checks only the instance it is about. Inputs change
// 1 ns after a rising edge and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_counter_nbit_up_down_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       direction = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;

    logic [2:0] cnt_a, cnt_s, cnt_d;
    logic       tc_a, tc_s, tc_d;
    logic       wrap_a, wrap_s, wrap_d;
    logic       ovf_a, ovf_s, ovf_d;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    counter_nbit_up_down_mod #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1'b0)) u_wrap5 (
        .clk(clk), .rst(rst), .en(en), .direction(direction), .load(load),
        .load_val(load_val), .count_out(cnt_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    counter_nbit_up_down_mod #(.WIDTH(3), .MAX_VAL(5), .SATURATE(1'b1)) u_sat5 (
        .clk(clk), .rst(rst), .en(en), .direction(direction), .load(load),
        .load_val(load_val), .count_out(cnt_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
    );

    counter_nbit_up_down_mod u_def (
        .clk(clk), .rst(rst), .en(en), .direction(direction), .load(load),
        .load_val(load_val), .count_out(cnt_d), .tc(tc_d), .wrap(wrap_d), .ovf(ovf_d)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset held two cycles: everything zero, tc low (direction up, 0 != 5).
    task automatic test_reset();
        rst = 1'b1; en = 1'b0; load = 1'b0; direction = 1'b0; load_val = 3'd0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++; if (cnt_a !== 3'd0) $display("FAIL reset_count cyc%0d got %0d exp 0", i, cnt_a); else n_pass++;
            n_checks++; if (wrap_a !== 1'b0) $display("FAIL reset_wrap cyc%0d got %b exp 0", i, wrap_a); else n_pass++;
            n_checks++; if (ovf_a !== 1'b0) $display("FAIL reset_ovf cyc%0d got %b exp 0", i, ovf_a); else n_pass++;
            n_checks++; if (tc_a !== 1'b0) $display("FAIL reset_tc cyc%0d got %b exp 0", i, tc_a); else n_pass++;
        end
    endtask

    // Up 7 cycles from 0 with MAX_VAL=5; load_val is X throughout to show
    // it is ignored while load is low.
    task automatic test_count_up();
        logic [2:0] exp_cnt  [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0, 3'd1};
        logic       exp_wrap [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_ovf  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_tc   [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rst = 1'b0; en = 1'b1; direction = 1'b0; load = 1'b0; load_val = 3'bxxx;
        for (int i = 0; i < 7; i++) begin
            tick();
            n_checks++; if (cnt_a !== exp_cnt[i]) $display("FAIL up_count step%0d got %0d exp %0d", i, cnt_a, exp_cnt[i]); else n_pass++;
            n_checks++; if (wrap_a !== exp_wrap[i]) $display("FAIL up_wrap step%0d got %b exp %b", i, wrap_a, exp_wrap[i]); else n_pass++;
            n_checks++; if (ovf_a !== exp_ovf[i]) $display("FAIL up_ovf step%0d got %b exp %b", i, ovf_a, exp_ovf[i]); else n_pass++;
            n_checks++; if (tc_a !== exp_tc[i]) $display("FAIL up_tc step%0d got %b exp %b", i, tc_a, exp_tc[i]); else n_pass++;
        end
    endtask

    // Load 3 (clears ovf), then down 5 cycles through the 0 -> 5 wrap.
    task automatic test_count_down();
        logic [2:0] exp_cnt  [5] = '{3'd2, 3'd1, 3'd0, 3'd5, 3'd4};
        logic       exp_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_ovf  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       exp_tc   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        load = 1'b1; load_val = 3'd3; en = 1'b0; direction = 1'b1;
        tick();
        n_checks++; if (cnt_a !== 3'd3) $display("FAIL down_load_count got %0d exp 3", cnt_a); else n_pass++;
        n_checks++; if (ovf_a !== 1'b0) $display("FAIL down_load_ovf got %b exp 0", ovf_a); else n_pass++;
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++; if (cnt_a !== exp_cnt[i]) $display("FAIL down_count step%0d got %0d exp %0d", i, cnt_a, exp_cnt[i]); else n_pass++;
            n_checks++; if (wrap_a !== exp_wrap[i]) $display("FAIL down_wrap step%0d got %b exp %b", i, wrap_a, exp_wrap[i]); else n_pass++;
            n_checks++; if (ovf_a !== exp_ovf[i]) $display("FAIL down_ovf step%0d got %b exp %b", i, ovf_a, exp_ovf[i]); else n_pass++;
            n_checks++; if (tc_a !== exp_tc[i]) $display("FAIL down_tc step%0d got %b exp %b", i, tc_a, exp_tc[i]); else n_pass++;
        end
    endtask

    // Saturating instance: load 4, up 3 -> 5,5,5, then reverse -> 4.
    task automatic test_saturate();
        logic [2:0] exp_cnt [3] = '{3'd5, 3'd5, 3'd5};
        logic       exp_ovf [3] = '{1'b0, 1'b1, 1'b1};
        load = 1'b1; load_val = 3'd4; en = 1'b0; direction = 1'b0;
        tick();
        n_checks++; if (cnt_s !== 3'd4) $display("FAIL sat_load_count got %0d exp 4", cnt_s); else n_pass++;
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (cnt_s !== exp_cnt[i]) $display("FAIL sat_count step%0d got %0d exp %0d", i, cnt_s, exp_cnt[i]); else n_pass++;
            n_checks++; if (wrap_s !== 1'b0) $display("FAIL sat_wrap step%0d got %b exp 0", i, wrap_s); else n_pass++;
            n_checks++; if (ovf_s !== exp_ovf[i]) $display("FAIL sat_ovf step%0d got %b exp %b", i, ovf_s, exp_ovf[i]); else n_pass++;
            n_checks++; if (tc_s !== 1'b1) $display("FAIL sat_tc step%0d got %b exp 1", i, tc_s); else n_pass++;
        end
        direction = 1'b1;
        tick();
        n_checks++; if (cnt_s !== 3'd4) $display("FAIL sat_reverse_count got %0d exp 4", cnt_s); else n_pass++;
        n_checks++; if (ovf_s !== 1'b1) $display("FAIL sat_reverse_ovf got %b exp 1", ovf_s); else n_pass++;
        n_checks++; if (wrap_s !== 1'b0) $display("FAIL sat_reverse_wrap got %b exp 0", wrap_s); else n_pass++;
    endtask

    // Set ovf by wrapping, then load 7 with en high: clamps to 5, ovf cleared.
    task automatic test_load_clamp();
        load = 1'b1; load_val = 3'd5; en = 1'b0; direction = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick();
        n_checks++; if (ovf_a !== 1'b1) $display("FAIL clamp_setup_ovf got %b exp 1", ovf_a); else n_pass++;
        n_checks++; if (cnt_a !== 3'd0) $display("FAIL clamp_setup_count got %0d exp 0", cnt_a); else n_pass++;
        load = 1'b1; load_val = 3'd7; en = 1'b1;
        tick();
        n_checks++; if (cnt_a !== 3'd5) $display("FAIL clamp_count got %0d exp 5", cnt_a); else n_pass++;
        n_checks++; if (ovf_a !== 1'b0) $display("FAIL clamp_ovf got %b exp 0", ovf_a); else n_pass++;
        n_checks++; if (wrap_a !== 1'b0) $display("FAIL clamp_wrap got %b exp 0", wrap_a); else n_pass++;
        n_checks++; if (cnt_s !== 3'd5) $display("FAIL clamp_sat_count got %0d exp 5", cnt_s); else n_pass++;
        n_checks++; if (cnt_d !== 3'd7) $display("FAIL clamp_def_count got %0d exp 7", cnt_d); else n_pass++;
        load = 1'b0;
    endtask

    // Reach 3 with ovf set, then rst+load+en together, hold 4, then resume.
    task automatic test_reset_override();
        load = 1'b1; load_val = 3'd5; en = 1'b0; direction = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        n_checks++; if (cnt_a !== 3'd3) $display("FAIL rstov_setup_count got %0d exp 3", cnt_a); else n_pass++;
        n_checks++; if (ovf_a !== 1'b1) $display("FAIL rstov_setup_ovf got %b exp 1", ovf_a); else n_pass++;
        rst = 1'b1; load = 1'b1; load_val = 3'd4; en = 1'b1;
        tick();
        n_checks++; if (cnt_a !== 3'd0) $display("FAIL rstov_count got %0d exp 0", cnt_a); else n_pass++;
        n_checks++; if (ovf_a !== 1'b0) $display("FAIL rstov_ovf got %b exp 0", ovf_a); else n_pass++;
        rst = 1'b0; load = 1'b0; en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (cnt_a !== 3'd0) $display("FAIL hold_count cyc%0d got %0d exp 0", i, cnt_a); else n_pass++;
            n_checks++; if (wrap_a !== 1'b0) $display("FAIL hold_wrap cyc%0d got %b exp 0", i, wrap_a); else n_pass++;
        end
        en = 1'b1;
        tick();
        n_checks++; if (cnt_a !== 3'd1) $display("FAIL resume_count got %0d exp 1", cnt_a); else n_pass++;
    endtask

    // Default instance: 30 cycles (300 ns), direction toggled every 10,
    // compared each cycle against a modulo-8 reference model.
    task automatic test_scoreboard();
        int m_cnt  = 0;
        int m_wrap = 0;
        int m_ovf  = 0;
        int m_tc;
        rst = 1'b1; load = 1'b0; en = 1'b0; direction = 1'b0;
        tick();
        rst = 1'b0; en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            direction = ((i / 10) % 2) == 1;
            tick();
            if (!direction) begin
                m_wrap = (m_cnt == 7) ? 1 : 0;
                m_cnt  = (m_cnt + 1) % 8;
            end else begin
                m_wrap = (m_cnt == 0) ? 1 : 0;
                m_cnt  = (m_cnt + 7) % 8;
            end
            if (m_wrap == 1) m_ovf = 1;
            m_tc = direction ? (m_cnt == 0) : (m_cnt == 7);
            n_checks++; if (cnt_d !== 3'(m_cnt)) $display("FAIL sb_count cyc%0d got %0d exp %0d", i, cnt_d, m_cnt); else n_pass++;
            n_checks++; if (tc_d !== 1'(m_tc)) $display("FAIL sb_tc cyc%0d got %b exp %0d", i, tc_d, m_tc); else n_pass++;
            n_checks++; if (wrap_d !== 1'(m_wrap)) $display("FAIL sb_wrap cyc%0d got %b exp %0d", i, wrap_d, m_wrap); else n_pass++;
            n_checks++; if (ovf_d !== 1'(m_ovf)) $display("FAIL sb_ovf cyc%0d got %b exp %0d", i, ovf_d, m_ovf); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_saturate();
        test_load_clamp();
        test_reset_override();
        test_scoreboard();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
